// File: rtl/range_burst_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : range_burst_sequencer_if
// Brief    : Sample-stream, burst-control and range-finder-facing signals of
//            the range burst sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface range_burst_sequencer_if #(
    parameter int WIDTH     = 8,
    parameter int LEN_WIDTH = 8
);
    logic [WIDTH-1:0]     sample_in;
    logic                 sample_valid;
    logic                 sample_ready;
    logic [LEN_WIDTH-1:0] burst_len;
    logic                 start;
    logic                 busy;
    logic [WIDTH-1:0]     data_out;
    logic                 go;
    logic                 finish;
    logic                 burst_done;
    logic                 len_error;

    modport master (
        output sample_in, sample_valid, burst_len, start,
        input  sample_ready, busy, data_out, go, finish, burst_done, len_error
    );

    modport slave (
        input  sample_in, sample_valid, burst_len, start,
        output sample_ready, busy, data_out, go, finish, burst_done, len_error
    );
endinterface
`default_nettype wire

// File: rtl/range_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : range_burst_sequencer
// Brief    : Buffers raw samples in a small FIFO and frames them into bursts
//            with single-cycle go/finish markers and a post-burst idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module range_burst_sequencer #(
    parameter int WIDTH      = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    range_burst_sequencer_if.slave bus
);
    localparam int                   c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_PTR_W:0]     c_DEPTH   = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]     c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
    localparam logic [LEN_WIDTH-1:0] c_LEN_ONE = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] c_LEN_MIN = LEN_WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_STREAM = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_pop_req;

    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [LEN_WIDTH-1:0] w_cnt_inc;
    logic                 r_gap;
    logic                 w_load;
    logic                 w_go_next;
    logic                 w_finish_next;
    logic                 w_done_next;
    logic                 w_lerr_next;

    logic [WIDTH-1:0]     r_data_out;
    logic                 r_go;
    logic                 r_finish;
    logic                 r_burst_done;
    logic                 r_len_error;

    // Ready comes from the registered full flag only; a pop never opens a slot
    // for a push in the same cycle.
    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_push    = bus.sample_valid && !w_full;
    assign w_pop     = w_pop_req && !w_empty;
    assign w_cnt_inc = r_cnt + c_LEN_ONE;

    assign w_go_next     = w_pop && (r_state == S_FIRST);
    assign w_finish_next = w_pop && (r_state == S_STREAM) && (w_cnt_inc == r_len);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // STREAM lingers for the finish output cycle (counter already equals the
    // length, so nothing pops) before the two GAP cycles begin.
    always_comb begin
        w_state_next = r_state;
        w_pop_req    = 1'b0;
        w_load       = 1'b0;
        w_lerr_next  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.burst_len >= c_LEN_MIN) begin
                        w_load       = 1'b1;
                        w_state_next = S_FIRST;
                    end else begin
                        w_lerr_next  = 1'b1;
                    end
                end
            end
            S_FIRST: begin
                w_pop_req = 1'b1;
                if (!w_empty) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (r_cnt == r_len) begin
                    w_state_next = S_GAP;
                end else begin
                    w_pop_req = 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.sample_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_len        <= '0;
            r_cnt        <= '0;
            r_gap        <= 1'b0;
            r_data_out   <= '0;
            r_go         <= 1'b0;
            r_finish     <= 1'b0;
            r_burst_done <= 1'b0;
            r_len_error  <= 1'b0;
        end else begin
            if (w_load) begin
                r_len <= bus.burst_len;
                r_cnt <= '0;
            end else if (w_pop) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_pop) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
            r_gap        <= (r_state == S_GAP) ? ~r_gap : 1'b0;
            r_go         <= w_go_next;
            r_finish     <= w_finish_next;
            r_burst_done <= w_done_next;
            r_len_error  <= w_lerr_next;
        end
    end

    assign bus.sample_ready = !w_full;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.data_out     = r_data_out;
    assign bus.go           = r_go;
    assign bus.finish       = r_finish;
    assign bus.burst_done   = r_burst_done;
    assign bus.len_error    = r_len_error;
endmodule
`default_nettype wire

// File: tb/tb_range_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_range_burst_sequencer
// Brief    : Scoreboard bench; a burst-level range-finder model judges every
//            go/finish framing against the samples actually handed over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_range_burst_sequencer;
    localparam int c_W     = 8;
    localparam int c_LW    = 8;
    localparam int c_DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    range_burst_sequencer_if #(.WIDTH(c_W), .LEN_WIDTH(c_LW)) bus ();

    range_burst_sequencer #(
        .WIDTH      (c_W),
        .LEN_WIDTH  (c_LW),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sample_q[$];
    int         len_q[$];
    int         cyc = 0, idle_at = -1, done_due = -1, lerr_due = -1;
    int         last_fin = -1, go_cyc = 0, cur_len = 0, last_range = -1;
    int         mn = 0, mx = 0, emn = 0, emx = 0;
    bit         mdl_idle = 1'b1, in_burst = 1'b0, post_reset = 1'b0, ok = 1'b0;
    logic [7:0] full_vals [6] = '{8'd20, 8'd40, 8'd11, 8'd33, 8'd55, 8'd66};

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: burst-level model of the attached range finder plus the
    // idle/busy/len_error timeline implied by accepted and rejected starts.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            sample_q.delete();
            len_q.delete();
            in_burst   = 1'b0;
            mdl_idle   = 1'b1;
            idle_at    = -1;
            done_due   = -1;
            lerr_due   = -1;
            last_fin   = -1;
            last_range = -1;
            post_reset = 1'b1;
        end else begin
            if (post_reset) begin
                check("rst_data_out", bus.data_out, 0);
                check("rst_go", bus.go, 0);
                check("rst_finish", bus.finish, 0);
                check("rst_ready", bus.sample_ready, 1);
                post_reset = 1'b0;
            end
            if (cyc == idle_at) mdl_idle = 1'b1;
            check("busy", bus.busy, !mdl_idle);
            if (bus.go) begin
                check("go_not_with_finish", bus.finish, 0);
                ok = !in_burst && (len_q.size() > 0) && (sample_q.size() > 0);
                check("go_expected", ok, 1);
                if (ok) begin
                    check("go_data", bus.data_out, sample_q[0]);
                    if (last_fin >= 0) check("finish_to_go_gap_ge4", (cyc - last_fin) >= 4, 1);
                    cur_len  = len_q.pop_front();
                    in_burst = 1'b1;
                    mn       = bus.data_out;
                    mx       = bus.data_out;
                    go_cyc   = cyc;
                end
            end else if (bus.finish) begin
                ok = in_burst && (sample_q.size() >= cur_len);
                check("finish_expected", ok, 1);
                if (ok) begin
                    if (bus.data_out < mn) mn = bus.data_out;
                    if (bus.data_out > mx) mx = bus.data_out;
                    emn = 255;
                    emx = 0;
                    for (int k = 0; k < cur_len; k++) begin
                        if (sample_q[k] < emn) emn = sample_q[k];
                        if (sample_q[k] > emx) emx = sample_q[k];
                    end
                    check("finish_data", bus.data_out, sample_q[cur_len-1]);
                    check("range", mx - mn, emx - emn);
                    check("burst_span", (cyc - go_cyc) >= (cur_len - 1), 1);
                    repeat (cur_len) void'(sample_q.pop_front());
                    last_range = mx - mn;
                    in_burst   = 1'b0;
                    last_fin   = cyc;
                    done_due   = cyc + 2;
                    idle_at    = cyc + 3;
                end
            end else if (in_burst) begin
                if (bus.data_out < mn) mn = bus.data_out;
                if (bus.data_out > mx) mx = bus.data_out;
            end
            check("burst_done", bus.burst_done, cyc == done_due);
            check("len_error", bus.len_error, cyc == lerr_due);
            if (bus.start && mdl_idle) begin
                if (bus.burst_len >= 2) begin
                    len_q.push_back(int'(bus.burst_len));
                    mdl_idle = 1'b0;
                end else begin
                    lerr_due = cyc + 1;
                end
            end
            if (bus.sample_valid && bus.sample_ready) sample_q.push_back(bus.sample_in);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input int v);
        bit acc = 1'b0;
        int t   = 0;
        bus.sample_in    = 8'(v);
        bus.sample_valid = 1'b1;
        while (!acc && t < 200) begin
            @(negedge clock);
            acc = bus.sample_ready;
            @(posedge clock);
            #1;
            t++;
        end
        bus.sample_valid = 1'b0;
        check("push_accepted", acc, 1);
    endtask

    task automatic do_start(input int len);
        bus.start     = 1'b1;
        bus.burst_len = 8'(len);
        idle(1);
        bus.start     = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!bus.burst_done && t < 300) begin
            idle(1);
            t++;
        end
        check("burst_done_seen", bus.burst_done, 1);
    endtask

    task automatic wait_go();
        int t = 0;
        while (!bus.go && t < 300) begin
            idle(1);
            t++;
        end
        check("go_seen", bus.go, 1);
    endtask

    initial begin
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.burst_len    = '0;
        bus.start        = 1'b0;
        reset            = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        idle(1);

        // Basic burst 5, 9, 2, 7
        push(5); push(9); push(2); push(7);
        do_start(4);
        wait_done();
        check("basic_range", last_range, 7);
        idle(1);

        // Rejected lengths
        do_start(1);
        idle(2);
        do_start(0);
        idle(2);
        check("rejected_idle", bus.busy, 0);

        // FIFO full, then a stalled burst of six
        for (int k = 0; k < 6; k++) begin
            bus.sample_in    = full_vals[k];
            bus.sample_valid = 1'b1;
            idle(1);
        end
        bus.sample_valid = 1'b0;
        check("fifo_accepts", sample_q.size(), c_DEPTH);
        check("full_ready", bus.sample_ready, 0);
        do_start(6);
        idle(3);
        push(50);
        push(8);
        wait_done();
        check("stall_range", last_range, 42);
        idle(1);

        // Back-to-back: start in the burst_done cycle, then again one later
        fork
            begin push(1); push(2); push(3); end
            do_start(3);
        join
        wait_done();
        do_start(3);
        do_start(3);
        push($urandom_range(0, 255));
        push($urandom_range(0, 255));
        push($urandom_range(0, 255));
        wait_done();
        idle(1);

        // Reset mid-burst
        push(100); push(20); push(200); push(60);
        do_start(5);
        wait_go();
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("post_reset_ready", bus.sample_ready, 1);
        check("post_reset_busy", bus.busy, 0);
        push(10);
        push(3);
        do_start(2);
        wait_done();
        check("post_reset_range", last_range, 7);
        idle(1);

        // Randomised bursts, including rejected lengths
        for (int b = 0; b < 40; b++) begin
            int len;
            len = $urandom_range(0, 9);
            if (len < 2) begin
                do_start(len);
                idle(2);
            end else begin
                fork
                    begin
                        for (int k = 0; k < len; k++) begin
                            idle($urandom_range(0, 2));
                            push($urandom_range(0, 255));
                        end
                    end
                    begin
                        idle($urandom_range(0, 3));
                        do_start(len);
                    end
                join
                wait_done();
                idle(1);
            end
        end
        idle(5);
        check("no_leftover_bursts", len_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
